// File: rtl/max31855_spi_rx.sv
// rtl/max31855_spi_rx.sv - read-only SPI master capturing one 32-bit MAX31855 frame
// Build option: define MISO_SYNC_EN to pass miso through a 2-flop synchronizer (needs CLK_DIV >= 3).
module max31855_spi_rx #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ena,
    input  logic        miso,
    output logic        spi_not_busy,
    output logic [31:0] spi_rx_data,
    output logic        rx_valid,
    output logic        cs_n,
    output logic        sclk
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic        miso_s;

`ifdef MISO_SYNC_EN
    logic [1:0] miso_sync;

    // Two-flop synchronizer; the bit seen at the sample edge left the pin two cycles earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = miso;
`endif

    // Frame sequencer: div_cnt holds the cycles left in the current phase minus one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= 8'd0;
            bit_cnt      <= 6'd0;
            shift_reg    <= 32'd0;
            spi_rx_data  <= 32'd0;
            rx_valid     <= 1'b0;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            spi_not_busy <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (spi_ena) begin
                        state        <= SETUP;
                        cs_n         <= 1'b0;
                        spi_not_busy <= 1'b0;
                        div_cnt      <= DIV_LOAD;
                        bit_cnt      <= 6'd0;
                    end
                end
                SETUP: begin
                    if (div_cnt == 8'd0) begin
                        state   <= SHIFT;
                        sclk    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (sclk) begin
                        // Falling sclk edge: data has been stable all high phase, capture it.
                        sclk      <= 1'b0;
                        shift_reg <= {shift_reg[30:0], miso_s};
                        div_cnt   <= DIV_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == 6'd31) begin
                            state <= HOLD;
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_cnt == 8'd0) begin
                        state       <= GAP;
                        cs_n        <= 1'b1;
                        spi_rx_data <= shift_reg;
                        rx_valid    <= 1'b1;
                        div_cnt     <= GAP_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (div_cnt == 8'd0) begin
                        state        <= IDLE;
                        spi_not_busy <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cs_n         <= 1'b1;
                    sclk         <= 1'b0;
                    spi_not_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max31855_spi_rx.sv
// tb/tb_max31855_spi_rx.sv - scoreboard bench for max31855_spi_rx (three parameter sets)
module tb_max31855_spi_rx;

    logic        clk;
    logic        rst;
    logic [2:0]  spi_ena;
    logic [2:0]  miso;
    logic [2:0]  spi_not_busy;
    logic [2:0]  rx_valid;
    logic [2:0]  cs_n;
    logic [2:0]  sclk;
    logic [31:0] rx_data [3];

    int n_cmp;
    int n_bad;

    logic [31:0] sbq0 [$];
    logic [31:0] sbq1 [$];
    logic [31:0] sbq2 [$];

    logic [31:0] dev_sr   [3];
    logic [31:0] dev_next [3];
    logic [2:0]  prev_cs;
    logic [2:0]  prev_sck;
    bit          alt_mode;

    localparam logic [31:0] ALT_A = 32'hAAAA_5555;
    localparam logic [31:0] ALT_B = 32'h8000_0001;

    max31855_spi_rx #(.CLK_DIV(4), .CS_IDLE(4)) u_dut0 (
        .clk(clk), .rst(rst), .spi_ena(spi_ena[0]), .miso(miso[0]),
        .spi_not_busy(spi_not_busy[0]), .spi_rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .cs_n(cs_n[0]), .sclk(sclk[0])
    );

    max31855_spi_rx #(.CLK_DIV(2), .CS_IDLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .spi_ena(spi_ena[1]), .miso(miso[1]),
        .spi_not_busy(spi_not_busy[1]), .spi_rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .cs_n(cs_n[1]), .sclk(sclk[1])
    );

    max31855_spi_rx #(.CLK_DIV(3), .CS_IDLE(4)) u_dut2 (
        .clk(clk), .rst(rst), .spi_ena(spi_ena[2]), .miso(miso[2]),
        .spi_not_busy(spi_not_busy[2]), .spi_rx_data(rx_data[2]),
        .rx_valid(rx_valid[2]), .cs_n(cs_n[2]), .sclk(sclk[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device model: loads a frame when cs_n falls, presents MSB, shifts after each sclk fall.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (prev_cs[i] && !cs_n[i]) begin
                dev_sr[i] = dev_next[i];
                case (i)
                    0: sbq0.push_back(dev_next[i]);
                    1: sbq1.push_back(dev_next[i]);
                    default: sbq2.push_back(dev_next[i]);
                endcase
                if (i == 0 && alt_mode) dev_next[0] = (dev_next[0] == ALT_A) ? ALT_B : ALT_A;
            end else if (!cs_n[i] && prev_sck[i] && !sclk[i]) begin
                dev_sr[i] = dev_sr[i] << 1;
            end
            miso[i]     = dev_sr[i][31];
            prev_cs[i]  = cs_n[i];
            prev_sck[i] = sclk[i];
        end
    end

    // Issues a one-cycle request and gathers frame statistics; no verdicts here.
    task automatic measure_frame(input int idx, input int div, output int cyc, output int cs_low,
                                 output int rises, output int bad_high, output int vcnt,
                                 output logic [31:0] got);
        int  run;
        bit  ps;
        cyc = 0; cs_low = 0; rises = 0; bad_high = 0; vcnt = 0; got = 32'hDEAD_BEEF;
        run = 0; ps = 1'b0;
        @(negedge clk);
        spi_ena[idx] = 1'b1;
        @(posedge clk);
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            spi_ena[idx] = 1'b0;
            if (!cs_n[idx]) cs_low++;
            if (sclk[idx]) run++;
            else begin
                if (run != 0 && run != div) bad_high++;
                run = 0;
            end
            if (sclk[idx] && !ps) rises++;
            ps = sclk[idx];
            if (rx_valid[idx]) begin
                vcnt++;
                got = rx_data[idx];
            end
            if (spi_not_busy[idx]) break;
        end
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (cs_n[0] !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n[0]); end
        n_cmp++; if (sclk[0] !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b exp=0", sclk[0]); end
        n_cmp++; if (spi_not_busy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_not_busy got=%b exp=1", spi_not_busy[0]); end
        n_cmp++; if (rx_data[0] !== 32'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", rx_data[0]); end
        n_cmp++; if (rx_valid[0] !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid[0]); end
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sclk != 3'b000 || cs_n != 3'b111 || rx_valid != 3'b000) act++;
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL idle_activity got=%0d exp=0", act); end
    endtask

    task automatic test_single_frame();
        int cyc, csl, rises, bh, vc;
        logic [31:0] got, exp;
        dev_next[0] = 32'h0C80_1910;
        measure_frame(0, 4, cyc, csl, rises, bh, vc, got);
        n_cmp++; if (cyc !== 269) begin n_bad++; $display("FAIL single_len got=%0d exp=269", cyc); end
        n_cmp++; if (csl !== 264) begin n_bad++; $display("FAIL single_cs_low got=%0d exp=264", csl); end
        n_cmp++; if (rises !== 32) begin n_bad++; $display("FAIL single_sclk_rises got=%0d exp=32", rises); end
        n_cmp++; if (bh !== 0) begin n_bad++; $display("FAIL single_high_width bad=%0d exp=0", bh); end
        n_cmp++; if (vc !== 1) begin n_bad++; $display("FAIL single_valid_pulses got=%0d exp=1", vc); end
        exp = (sbq0.size() > 0) ? sbq0.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL single_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        int pulses, n, gap_run, min_gap, stable_bad;
        logic [31:0] last, exp;
        bit in_frame;
        alt_mode = 1'b1;
        dev_next[0] = ALT_A;
        pulses = 0; n = 0; gap_run = 0; min_gap = 1000; stable_bad = 0; in_frame = 1'b0;
        last = rx_data[0];
        @(negedge clk);
        spi_ena[0] = 1'b1;
        while (pulses < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (cs_n[0]) gap_run++;
            else begin
                if (in_frame && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
                in_frame = 1'b1;
                gap_run = 0;
            end
            if (rx_valid[0]) begin
                pulses++;
                exp = (sbq0.size() > 0) ? sbq0.pop_front() : 32'hxxxx_xxxx;
                n_cmp++; if (rx_data[0] !== exp) begin n_bad++; $display("FAIL b2b_data%0d got=%h exp=%h", pulses, rx_data[0], exp); end
                last = rx_data[0];
            end else if (rx_data[0] !== last) begin
                stable_bad++;
            end
        end
        spi_ena[0] = 1'b0;
        alt_mode = 1'b0;
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b_frames got=%0d exp=4", pulses); end
        n_cmp++; if (min_gap < 4 || min_gap == 1000) begin n_bad++; $display("FAIL b2b_cs_gap got=%0d exp>=4", min_gap); end
        n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL b2b_data_stable changes=%0d exp=0", stable_bad); end
        n = 0;
        while (!spi_not_busy[0] && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (spi_not_busy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_return_idle got=%b exp=1", spi_not_busy[0]); end
        n_cmp++; if (sbq0.size() !== 0) begin n_bad++; $display("FAIL b2b_queue_left got=%0d exp=0", sbq0.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int rises, n, cyc, csl, r2, bh, vc;
        bit ps;
        logic [31:0] got, exp;
        dev_next[0] = 32'h5A5A_C3C3;
        rises = 0; n = 0; ps = 1'b0; vc = 0;
        @(negedge clk);
        spi_ena[0] = 1'b1;
        while (rises < 17 && n < 2000) begin
            @(negedge clk);
            n++;
            spi_ena[0] = 1'b0;
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
            if (rx_valid[0]) vc++;
        end
        n_cmp++; if (rises !== 17) begin n_bad++; $display("FAIL rst_reach_edge17 got=%0d exp=17", rises); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (cs_n[0] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_cs_n got=%b exp=1", cs_n[0]); end
        n_cmp++; if (sclk[0] !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sclk got=%b exp=0", sclk[0]); end
        n_cmp++; if (rx_data[0] !== 32'd0) begin n_bad++; $display("FAIL rst_mid_data got=%h exp=0", rx_data[0]); end
        n_cmp++; if (rx_valid[0] !== 1'b0 || vc !== 0) begin n_bad++; $display("FAIL rst_mid_valid got=%b/%0d exp=0", rx_valid[0], vc); end
        n_cmp++; if (spi_not_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_not_busy got=%b exp=1", spi_not_busy[0]); end
        sbq0.delete();
        dev_next[0] = 32'hFFFF_FFFF;
        measure_frame(0, 4, cyc, csl, r2, bh, vc, got);
        exp = (sbq0.size() > 0) ? sbq0.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_next_data got=%h exp=%h", got, exp); end
        n_cmp++; if (cyc !== 269) begin n_bad++; $display("FAIL rst_next_len got=%0d exp=269", cyc); end
    endtask

    task automatic test_min_div();
        int cyc, csl, rises, bh, vc;
        logic [31:0] got, exp;
        dev_next[1] = 32'h0000_0001;
        measure_frame(1, 2, cyc, csl, rises, bh, vc, got);
        n_cmp++; if (cyc !== 134) begin n_bad++; $display("FAIL div2_len got=%0d exp=134", cyc); end
        n_cmp++; if (csl !== 132) begin n_bad++; $display("FAIL div2_cs_low got=%0d exp=132", csl); end
        n_cmp++; if (rises !== 32 || bh !== 0) begin n_bad++; $display("FAIL div2_sclk rises=%0d badw=%0d exp=32/0", rises, bh); end
        n_cmp++; if (vc !== 1) begin n_bad++; $display("FAIL div2_valid_pulses got=%0d exp=1", vc); end
        exp = (sbq1.size() > 0) ? sbq1.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL div2_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_div3_sync();
        int cyc, csl, rises, bh, vc;
        logic [31:0] got, exp;
        dev_next[2] = 32'h1234_5678;
        measure_frame(2, 3, cyc, csl, rises, bh, vc, got);
        n_cmp++; if (cyc !== 66 * 3 + 4 + 1) begin n_bad++; $display("FAIL div3_len got=%0d exp=%0d", cyc, 66 * 3 + 5); end
        n_cmp++; if (csl !== 198) begin n_bad++; $display("FAIL div3_cs_low got=%0d exp=198", csl); end
        n_cmp++; if (rises !== 32 || bh !== 0) begin n_bad++; $display("FAIL div3_sclk rises=%0d badw=%0d exp=32/0", rises, bh); end
        exp = (sbq2.size() > 0) ? sbq2.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL div3_data got=%h exp=%h", got, exp); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        spi_ena = 3'b000;
        alt_mode = 1'b0;
        prev_cs = 3'b111;
        prev_sck = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dev_sr[i] = 32'd0;
            dev_next[i] = 32'd0;
        end
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_div();
        test_div3_sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/max31855_spi_rx.md
Name: max31855_spi_rx

Overview:
- Read-only SPI master that clocks one 32-bit frame out of a MAX31855-class thermocouple converter.
- Sits directly upstream of the thermocouple decode stage.
- Takes spi_ena from that stage; returns spi_not_busy and the assembled frame spi_rx_data, from which the decoder slices temperature, junction and fault fields.
- Drives the chip's cs_n and sclk pins and samples miso.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range 2..255 (3..255 when MISO_SYNC_EN is defined).
CS_IDLE, 4, minimum clk cycles cs_n stays high after a frame before a new frame may start; legal range 1..255.

Ports:
clk  input  1  system clock.
rst  input  1  reset: synchronous, active-high.
spi_ena  input  1  request a frame; sampled only in IDLE.
miso  input  1  serial data from the device.
spi_not_busy  output  1  1 = IDLE, ready for a request.
spi_rx_data  output  32  last complete frame, MSB = first bit received.
rx_valid  output  1  one-cycle pulse when spi_rx_data updates.
cs_n  output  1  device chip select, active low.
sclk  output  1  serial clock; idles low.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state, including mid-frame:
  - Next cycle: state=IDLE, cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0, rx_valid=0.
  - Shift register and all counters cleared.
  - A partial frame is discarded.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - spi_not_busy=1, cs_n=1, sclk=0.
  - spi_ena=1 sampled at edge t → at t+1 state=SETUP, cs_n=0, spi_not_busy=0.
- SETUP:
  - cs_n=0, sclk=0 for CLK_DIV cycles (chip-select setup), then SHIFT.
- SHIFT:
  - 32 sclk periods; each is CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0. The first period starts high.
  - Sample point: on the clk edge that drives sclk 1→0, shift the sampled miso into the LSB of a 32-bit shift register (MSB-first).
  - The device changes data on sclk falling edges, so the sample is taken at the last cycle of the high phase.
  - A 6-bit bit counter counts sclk periods. After the 32nd low phase completes → HOLD.
- HOLD:
  - cs_n=0, sclk=0 for CLK_DIV cycles.
  - On exit: cs_n=1, spi_rx_data ← shift register, rx_valid=1 for exactly that one cycle → GAP.
- GAP:
  - cs_n=1, spi_not_busy=0 for CS_IDLE cycles, then IDLE with spi_not_busy=1.
- Frame length: from the IDLE edge sampling spi_ena to spi_not_busy returning to 1 is (66·CLK_DIV + CS_IDLE + 1) cycles = 269 at defaults.
- spi_rx_data is held stable between rx_valid pulses. It never shows a partial frame.
- spi_ena is ignored outside IDLE. If spi_ena is still 1 on the first IDLE cycle, a new frame starts immediately; back-to-back frames are legal.
- spi_ena is level-sensitive. The consumer holds it while spi_not_busy=1 and drops it after seeing spi_not_busy=0.
- Divider counter: 8-bit, reloads at every phase boundary. CLK_DIV values outside the legal range are unsupported.

Optional Feature:
- Macro: MISO_SYNC_EN.
- Defined:
  - miso passes through a 2-flop synchronizer before the shift register.
  - The sample point is unchanged (the edge driving sclk 1→0), so the captured bit is miso from 2 cycles earlier, still inside the high phase.
  - Requires CLK_DIV≥3.
  - Synchronizer flops reset to 0.
- Undefined:
  - miso is sampled directly.
  - No added flops; CLK_DIV≥2.
- Frame timing and all outputs are identical in both builds for a device that holds data stable through the high phase.

Test Plan:
1. Reset then idle, defaults → cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0, rx_valid=0; no sclk activity for 1000 cycles with spi_ena=0.
2. Device model shifts 0x0C80_1910; pulse spi_ena for 1 cycle →
   - cs_n low for 264 cycles; exactly 32 sclk rising edges, each high 4 cycles;
   - rx_valid single pulse; spi_rx_data=0x0C80_1910;
   - spi_not_busy=1 exactly 269 cycles after the request edge.
3. spi_ena held at 1 continuously, model alternates 0xAAAA_5555 / 0x8000_0001 → back-to-back frames with ≥4 cs_n-high cycles between; spi_rx_data tracks each frame; no update between pulses.
4. Assert rst at the 17th sclk rising edge → next cycle cs_n=1, sclk=0, spi_rx_data=0, no rx_valid. A following request returns the full new frame 0xFFFF_FFFF.
5. Set CLK_DIV=2, CS_IDLE=1, frame 0x0000_0001 → 134-cycle frame; LSB captured correctly.
6. Build with MISO_SYNC_EN, CLK_DIV=3, frame 0x1234_5678 → spi_rx_data=0x1234_5678, frame timing identical to the unsynchronized build with the same parameters.
